program_counter: RTL and testbench



---
 rtl/pc_pkg.sv | 13 +
 rtl/pc_next_calc.sv | 37 +++
 rtl/program_counter.sv | 56 +++++
 tb/tb_program_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the highRISC program counter.
// Optional stall input is enabled by defining PROGRAM_COUNTER_STALL_EN.
package pc_pkg;

   localparam int PC_WIDTH        = 16;
   localparam int PC_OFFSET_WIDTH = 9;

   typedef logic [PC_WIDTH-1:0]               pc_t;
   typedef logic signed [PC_OFFSET_WIDTH-1:0] pc_offset_t;

   localparam pc_t PC_RESET_VALUE = '0;

endpackage : pc_pkg

// File: rtl/pc_next_calc.sv
// Next fetch address selection: load > relative offset > increment.
// All arithmetic wraps modulo 2^WIDTH; Offset is sign-extended before the add.
module pc_next_calc
   import pc_pkg::*;
#(
   parameter int WIDTH        = PC_WIDTH,
   parameter int OFFSET_WIDTH = PC_OFFSET_WIDTH
) (
   input  logic [WIDTH-1:0]               CurrentValue,
   input  logic [WIDTH-1:0]               LoadValue,
   input  logic                           LoadEnable,
   input  logic signed [OFFSET_WIDTH-1:0] Offset,
   input  logic                           OffsetEnable,
   output logic [WIDTH-1:0]               NextValue
);

   logic [WIDTH-1:0] offsetExt_s;
   logic [WIDTH-1:0] nextValue_s;

   // Casting a signed operand to WIDTH replicates its sign bit, even when the widths match.
   assign offsetExt_s = WIDTH'(Offset);

   // Priority select of the candidate next value.
   always_comb begin
      nextValue_s = CurrentValue + WIDTH'(1'b1);
      if (LoadEnable) begin
         nextValue_s = LoadValue;
      end else if (OffsetEnable) begin
         nextValue_s = CurrentValue + offsetExt_s;
      end else begin
         nextValue_s = CurrentValue + WIDTH'(1'b1);
      end
   end

   assign NextValue = nextValue_s;

endmodule : pc_next_calc

// File: rtl/program_counter.sv
// Program counter register with asynchronous active-high reset.
// Define PROGRAM_COUNTER_STALL_EN to add a Stall input that freezes the counter.
module program_counter
   import pc_pkg::*;
#(
   parameter int WIDTH        = PC_WIDTH,
   parameter int OFFSET_WIDTH = PC_OFFSET_WIDTH
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic [WIDTH-1:0]               LoadValue,
   input  logic                           LoadEnable,
   input  logic signed [OFFSET_WIDTH-1:0] Offset,
   input  logic                           OffsetEnable,
`ifdef PROGRAM_COUNTER_STALL_EN
   input  logic                           Stall,
`endif
   output logic [WIDTH-1:0]               CounterValue
);

   logic [WIDTH-1:0] counter_r;
   logic [WIDTH-1:0] nextValue_s;
   logic             stall_s;

`ifdef PROGRAM_COUNTER_STALL_EN
   assign stall_s = Stall;
`else
   assign stall_s = 1'b0;
`endif

   pc_next_calc #(
      .WIDTH        (WIDTH),
      .OFFSET_WIDTH (OFFSET_WIDTH)
   ) u_nextCalc (
      .CurrentValue (counter_r),
      .LoadValue    (LoadValue),
      .LoadEnable   (LoadEnable),
      .Offset       (Offset),
      .OffsetEnable (OffsetEnable),
      .NextValue    (nextValue_s)
   );

   // Counter register; stall holds the value and outranks every update except reset.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         counter_r <= WIDTH'(PC_RESET_VALUE);
      end else if (stall_s) begin
         counter_r <= counter_r;
      end else begin
         counter_r <= nextValue_s;
      end
   end

   assign CounterValue = counter_r;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed-vector bench for program_counter with an integer reference model
// compared every falling edge; define PROGRAM_COUNTER_STALL_EN to cover Stall.
`timescale 1ns/1ps
module tb_program_counter;

   logic              Clock = 1'b0;
   logic              Reset = 1'b0;
   logic [15:0]       LoadValue = 16'd0;
   logic              LoadEnable = 1'b0;
   logic signed [8:0] Offset = 9'sd0;
   logic              OffsetEnable = 1'b0;
   logic              Stall = 1'b0;
   logic [15:0]       CounterValue;

   int nChecks = 0;
   int nFail   = 0;
   int expVal  = 0;

   program_counter #(.WIDTH(16), .OFFSET_WIDTH(9)) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .LoadValue    (LoadValue),
      .LoadEnable   (LoadEnable),
      .Offset       (Offset),
      .OffsetEnable (OffsetEnable),
`ifdef PROGRAM_COUNTER_STALL_EN
      .Stall        (Stall),
`endif
      .CounterValue (CounterValue)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge Clock);
   endtask

   // Reference model: plain integer arithmetic modulo 65536.
   always @(posedge Clock or posedge Reset) begin
      if (Reset) expVal = 0;
`ifdef PROGRAM_COUNTER_STALL_EN
      else if (Stall) expVal = expVal;
`endif
      else if (LoadEnable) expVal = int'(LoadValue);
      else if (OffsetEnable) expVal = (expVal + int'(Offset)) & 32'h0000FFFF;
      else expVal = (expVal + 1) & 32'h0000FFFF;
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge Clock) begin
      check("model", CounterValue, expVal[15:0]);
   end

   task automatic loadTo(input logic [15:0] v);
      LoadValue = v; LoadEnable = 1'b1;
      step(1);
      LoadEnable = 1'b0;
   endtask

   task automatic branch(input logic signed [8:0] off);
      Offset = off; OffsetEnable = 1'b1;
      step(1);
      OffsetEnable = 1'b0;
   endtask

   initial begin
      #1 Reset = 1'b1;
      step(2);
      check("reset_value", CounterValue, 16'd0);
      Reset = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         step(1);
         check("count_from_reset", CounterValue, 16'(i));
      end

      #2 Reset = 1'b1;
      #1 check("async_reset", CounterValue, 16'd0);
      step(1);
      check("reset_held", CounterValue, 16'd0);
      Reset = 1'b0;

      LoadValue = 16'd1000;
      step(5);
      check("load_ignored", CounterValue, 16'd5);
      loadTo(16'd1000);
      check("load_1000", CounterValue, 16'd1000);
      step(5);
      check("after_load_1005", CounterValue, 16'd1005);

      Offset = -9'sd200;
      step(5);
      check("offset_ignored", CounterValue, 16'd1010);
      branch(-9'sd200);
      check("offset_m200", CounterValue, 16'd810);
      step(1);
      check("after_offset", CounterValue, 16'd811);

      loadTo(16'd100);
      branch(9'sd255);
      check("offset_p255", CounterValue, 16'd355);
      loadTo(16'd300);
      branch(-9'sd256);
      check("offset_m256", CounterValue, 16'd44);
      loadTo(16'd5);
      branch(-9'sd10);
      check("offset_wrap", CounterValue, 16'hFFFB);

      loadTo(16'hFFFF);
      step(1);
      check("incr_wrap", CounterValue, 16'h0000);

      LoadValue = 16'h1234; Offset = 9'sd4;
      LoadEnable = 1'b1; OffsetEnable = 1'b1;
      step(1);
      LoadEnable = 1'b0; OffsetEnable = 1'b0;
      check("load_beats_offset", CounterValue, 16'h1234);
      step(1);
      check("after_both", CounterValue, 16'h1235);

      Offset = 9'sd3; OffsetEnable = 1'b1;
      step(3);
      OffsetEnable = 1'b0;
      check("offset_held", CounterValue, 16'h123E);
      LoadValue = 16'd77; LoadEnable = 1'b1;
      step(2);
      LoadEnable = 1'b0;
      check("load_held", CounterValue, 16'd77);

`ifdef PROGRAM_COUNTER_STALL_EN
      loadTo(16'd42);
      Stall = 1'b1; LoadValue = 16'd999; LoadEnable = 1'b1;
      step(3);
      check("stall_hold", CounterValue, 16'd42);
      Stall = 1'b0; LoadEnable = 1'b0;
      step(1);
      check("stall_release", CounterValue, 16'd43);
      Stall = 1'b1;
      step(1);
      #2 Reset = 1'b1;
      #1 check("reset_in_stall", CounterValue, 16'd0);
      step(1);
      Reset = 1'b0; Stall = 1'b0;
      step(1);
      check("after_stall_reset", CounterValue, 16'd1);
`endif

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule : tb_program_counter
